// File: rtl/io64_uart_tx_if.sv
// Purpose: CPU output-port word in, UART line and queue status out.
// Latency: plain wires, no registers.
// Backpressure: none; the peripheral drops words and flags OVERFLOW when its queue is full.
interface io64_uart_tx_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [15:0]   IO64_IN;
  logic          TX;
  logic          BUSY;
  logic          OVERFLOW;
  logic [LW-1:0] FIFO_LEVEL;

  // CPU / testbench side.
  modport master (
    output IO64_IN,
    input  TX,
    input  BUSY,
    input  OVERFLOW,
    input  FIFO_LEVEL
  );

  // Peripheral side.
  modport slave (
    input  IO64_IN,
    output TX,
    output BUSY,
    output OVERFLOW,
    output FIFO_LEVEL
  );
endinterface

// File: rtl/io64_uart_tx.sv
// Purpose: queue every change of IO64_IN and send it as two UART frames, high byte first (8N1, or 8E1 with IO64_UART_PARITY_EN).
// Latency: a change reaches the FIFO on its edge; TX falls 2 cycles after the change when idle; a word is 20 (22) bit times.
// Backpressure: none upstream; a change that arrives while the FIFO is full and not popping is dropped and sets sticky OVERFLOW.
module io64_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  io64_uart_tx_if.slave io
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Change detect and queue
  logic [15:0]   prev_q;
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          overflow_q;
  logic          push_req;
  logic          push_ok;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;

  // Serializer
  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    bit_idx, bit_idx_d;
  logic          byte_sel, byte_sel_d;
  logic [15:0]   shift_word, shift_word_d;
  logic [7:0]    cur_byte;
  logic          bit_end;
  logic          tx;

  assign push_req   = (io.IO64_IN != prev_q);
  assign fifo_full  = (level == LW'(FIFO_DEPTH));
  assign fifo_empty = (level == '0);
  assign pop        = (state == IDLE) && !fifo_empty;
  // A pop on the same edge frees the slot, so a push into a full FIFO is still accepted.
  assign push_ok    = push_req && (!fifo_full || pop);

  // Queue storage; not reset since the pointers and level define validity.
  always_ff @(posedge CLK) begin
    if (!RESET && push_ok) begin
      mem[wr_ptr] <= io.IO64_IN;
    end
  end

  // Change detection, FIFO pointers/level and sticky overflow flag.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      prev_q     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow_q <= 1'b0;
    end else begin
      prev_q <= io.IO64_IN;
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (push_req && !push_ok) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Serializer state registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      byte_sel   <= 1'b0;
      shift_word <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      bit_idx    <= bit_idx_d;
      byte_sel   <= byte_sel_d;
      shift_word <= shift_word_d;
    end
  end

  assign bit_end  = (cnt == CW'(CLKS_PER_BIT - 1));
  assign cur_byte = byte_sel ? shift_word[7:0] : shift_word[15:8];

  // Next-state logic: each bit lasts CLKS_PER_BIT cycles, counter restarts on every advance.
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    bit_idx_d    = bit_idx;
    byte_sel_d   = byte_sel;
    shift_word_d = shift_word;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          shift_word_d = mem[rd_ptr];
          byte_sel_d   = 1'b0;
          cnt_d        = '0;
          state_d      = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_idx == 3'd7) begin
`ifdef IO64_UART_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx + 3'd1;
          end
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = STOP;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (!byte_sel) begin
            byte_sel_d = 1'b1;
            state_d    = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Line level decoded from registered state only, so TX is high on the reset edge.
  always_comb begin
    tx = 1'b1;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = cur_byte[bit_idx];
      PARITY:  tx = ^cur_byte;
      default: tx = 1'b1;
    endcase
  end

  assign io.TX         = tx;
  assign io.BUSY       = (state != IDLE) || !fifo_empty;
  assign io.OVERFLOW   = overflow_q;
  assign io.FIFO_LEVEL = level;

endmodule

// File: tb/tb_io64_uart_tx.sv
// Purpose: directed self-checking bench for io64_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled at the same point.
// Backpressure: a bench-side UART receiver decodes TX; every wait is bounded.
module tb_io64_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef IO64_UART_PARITY_EN
  localparam int BITS = 11;
`else
  localparam int BITS = 10;
`endif
  localparam int WORD_CYC = 2 * BITS * CPB;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  io64_uart_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();

  io64_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .io   (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Hold reset for two edges, then release with IO64_IN at the given value.
  task automatic reset_to(input logic [15:0] v);
    RESET = 1'b1;
    bus.IO64_IN = 16'h0000;
    step(2);
    RESET = 1'b0;
    bus.IO64_IN = v;
  endtask

  // Bench UART receiver: waits for a low line, then samples each bit mid-period.
  task automatic rx_byte(output logic [7:0] b, output logic frame_ok,
                         output logic par, output int fall_cyc);
    logic got;
    logic st;
    logic sp;
    got = 1'b0;
    fall_cyc = 0;
    b = 8'h00;
    par = 1'b0;
    frame_ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.TX === 1'b0) begin
        got = 1'b1;
        fall_cyc = cyc;
        break;
      end
      step(1);
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL rx_start_timeout got=no_falling_edge exp=falling_edge within 200 cycles");
    end else begin
      step(CPB / 2);
      st = bus.TX;
      for (int i = 0; i < 8; i++) begin
        step(CPB);
        b[i] = bus.TX;
      end
`ifdef IO64_UART_PARITY_EN
      step(CPB);
      par = bus.TX;
`endif
      step(CPB);
      sp = bus.TX;
      frame_ok = (st === 1'b0) && (sp === 1'b1);
    end
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    bus.IO64_IN = 16'hFFFF;
    step(2);
    checks++; if (bus.TX !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", bus.TX); end
    checks++; if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.BUSY); end
    checks++; if (bus.OVERFLOW !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", bus.OVERFLOW); end
    checks++; if (bus.FIFO_LEVEL !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", bus.FIFO_LEVEL); end
  endtask

  task automatic test_no_traffic;
    reset_to(16'h0000);
    for (int i = 0; i < 200; i++) begin
      step(1);
      checks++;
      if (bus.TX !== 1'b1 || bus.BUSY !== 1'b0 || bus.FIFO_LEVEL !== 3'd0) begin
        failures++;
        $display("FAIL idle_quiet cycle=%0d got tx=%b busy=%b level=%0d exp tx=1 busy=0 level=0",
                 i, bus.TX, bus.BUSY, bus.FIFO_LEVEL);
      end
    end
  endtask

  task automatic test_basic_frame;
    logic [7:0] hi, lo;
    logic ok_hi, ok_lo, p_hi, p_lo;
    int f_hi, f_lo, c0;
    reset_to(16'h12A5);
    c0 = cyc;
    step(1);
    checks++; if (bus.TX !== 1'b1) begin failures++; $display("FAIL basic_tx_after_push got=%b exp=1", bus.TX); end
    checks++; if (bus.FIFO_LEVEL !== 3'd1) begin failures++; $display("FAIL basic_level_after_push got=%0d exp=1", bus.FIFO_LEVEL); end
    checks++; if (bus.BUSY !== 1'b1) begin failures++; $display("FAIL basic_busy_after_push got=%b exp=1", bus.BUSY); end
    step(1);
    checks++; if (bus.TX !== 1'b0) begin failures++; $display("FAIL basic_tx_fall_latency got=%b exp=0", bus.TX); end
    rx_byte(hi, ok_hi, p_hi, f_hi);
    rx_byte(lo, ok_lo, p_lo, f_lo);
    checks++; if (f_hi !== c0 + 2) begin failures++; $display("FAIL basic_fall_cycle got=%0d exp=%0d", f_hi, c0 + 2); end
    checks++; if (hi !== 8'h12) begin failures++; $display("FAIL basic_high_byte got=%h exp=12", hi); end
    checks++; if (lo !== 8'hA5) begin failures++; $display("FAIL basic_low_byte got=%h exp=a5", lo); end
    checks++; if (!(ok_hi && ok_lo)) begin failures++; $display("FAIL basic_framing got=%b%b exp=11", ok_hi, ok_lo); end
    checks++; if (f_lo - f_hi !== BITS * CPB) begin failures++; $display("FAIL basic_byte_spacing got=%0d exp=%0d", f_lo - f_hi, BITS * CPB); end
`ifdef IO64_UART_PARITY_EN
    checks++; if (p_hi !== 1'b0 || p_lo !== 1'b0) begin failures++; $display("FAIL basic_parity got=%b%b exp=00", p_hi, p_lo); end
`endif
    while (cyc < c0 + 1 + WORD_CYC) step(1);
    checks++; if (bus.BUSY !== 1'b1) begin failures++; $display("FAIL basic_busy_last got=%b exp=1", bus.BUSY); end
    step(1);
    checks++; if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL basic_busy_clear got=%b exp=0", bus.BUSY); end
    checks++; if (bus.TX !== 1'b1) begin failures++; $display("FAIL basic_tx_idle got=%b exp=1", bus.TX); end
  endtask

  task automatic test_overflow;
    logic [15:0] words [5];
    int falls [5];
    reset_to(16'h0000);
    fork
      begin
        for (int v = 1; v <= 7; v++) begin
          bus.IO64_IN = 16'(v);
          step(1);
        end
        checks++; if (bus.FIFO_LEVEL !== 3'd4) begin failures++; $display("FAIL ovf_level got=%0d exp=4", bus.FIFO_LEVEL); end
        checks++; if (bus.OVERFLOW !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", bus.OVERFLOW); end
      end
      begin
        logic [7:0] hi, lo;
        logic ok_hi, ok_lo, p_hi, p_lo;
        int f_lo;
        for (int k = 0; k < 5; k++) begin
          rx_byte(hi, ok_hi, p_hi, falls[k]);
          rx_byte(lo, ok_lo, p_lo, f_lo);
          words[k] = (ok_hi && ok_lo) ? {hi, lo} : 16'hDEAD;
        end
      end
    join
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (words[k] !== 16'(k + 1)) begin
        failures++;
        $display("FAIL ovf_word%0d got=%h exp=%h", k, words[k], 16'(k + 1));
      end
    end
    for (int k = 1; k < 5; k++) begin
      checks++;
      if (falls[k] - falls[k-1] !== WORD_CYC + 1) begin
        failures++;
        $display("FAIL back_to_back_gap%0d got=%0d exp=%0d", k, falls[k] - falls[k-1], WORD_CYC + 1);
      end
    end
    step(WORD_CYC);
    checks++; if (bus.OVERFLOW !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", bus.OVERFLOW); end
    checks++; if (bus.BUSY !== 1'b0 || bus.FIFO_LEVEL !== 3'd0) begin failures++; $display("FAIL ovf_drained got busy=%b level=%0d exp busy=0 level=0", bus.BUSY, bus.FIFO_LEVEL); end
  endtask

  task automatic test_full_pop;
    int c2;
    reset_to(16'h0001);
    step(1);
    step(1);
    c2 = cyc;
    for (int v = 2; v <= 5; v++) begin
      bus.IO64_IN = 16'(v);
      step(1);
    end
    checks++; if (bus.FIFO_LEVEL !== 3'd4) begin failures++; $display("FAIL full_level got=%0d exp=4", bus.FIFO_LEVEL); end
    while (cyc < c2 + WORD_CYC) step(1);
    checks++; if (bus.TX !== 1'b1 || bus.BUSY !== 1'b1) begin failures++; $display("FAIL full_idle_cycle got tx=%b busy=%b exp tx=1 busy=1", bus.TX, bus.BUSY); end
    bus.IO64_IN = 16'h0006;
    step(1);
    checks++; if (bus.FIFO_LEVEL !== 3'd4) begin failures++; $display("FAIL full_pop_push_level got=%0d exp=4", bus.FIFO_LEVEL); end
    checks++; if (bus.OVERFLOW !== 1'b0) begin failures++; $display("FAIL full_pop_push_overflow got=%b exp=0", bus.OVERFLOW); end
    checks++; if (bus.TX !== 1'b0) begin failures++; $display("FAIL full_pop_start got=%b exp=0", bus.TX); end
    bus.IO64_IN = 16'h0007;
    step(1);
    checks++; if (bus.OVERFLOW !== 1'b1) begin failures++; $display("FAIL full_drop_overflow got=%b exp=1", bus.OVERFLOW); end
    checks++; if (bus.FIFO_LEVEL !== 3'd4) begin failures++; $display("FAIL full_drop_level got=%0d exp=4", bus.FIFO_LEVEL); end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] hi, lo;
    logic ok_hi, ok_lo, p_hi, p_lo;
    int f0, f_hi, f_lo;
    reset_to(16'hBEEF);
    step(2);
    f0 = cyc;
    checks++; if (bus.TX !== 1'b0) begin failures++; $display("FAIL mid_start got=%b exp=0", bus.TX); end
    while (cyc < f0 + 17) step(1);
    RESET = 1'b1;
    step(1);
    checks++; if (bus.TX !== 1'b1) begin failures++; $display("FAIL mid_reset_tx got=%b exp=1", bus.TX); end
    checks++; if (bus.FIFO_LEVEL !== 3'd0 || bus.BUSY !== 1'b0) begin failures++; $display("FAIL mid_reset_state got level=%0d busy=%b exp level=0 busy=0", bus.FIFO_LEVEL, bus.BUSY); end
    checks++; if (bus.OVERFLOW !== 1'b0) begin failures++; $display("FAIL mid_reset_overflow got=%b exp=0", bus.OVERFLOW); end
    RESET = 1'b0;
    rx_byte(hi, ok_hi, p_hi, f_hi);
    rx_byte(lo, ok_lo, p_lo, f_lo);
    checks++; if (f_hi !== f0 + 20) begin failures++; $display("FAIL mid_resend_fall got=%0d exp=%0d", f_hi, f0 + 20); end
    checks++; if ({hi, lo} !== 16'hBEEF || !(ok_hi && ok_lo)) begin failures++; $display("FAIL mid_resend_word got=%h frame=%b%b exp=beef frame=11", {hi, lo}, ok_hi, ok_lo); end
  endtask

`ifdef IO64_UART_PARITY_EN
  task automatic test_parity;
    logic [7:0] hi, lo;
    logic ok_hi, ok_lo, p_hi, p_lo;
    int f_hi, f_lo, c0;
    reset_to(16'h0301);
    c0 = cyc;
    rx_byte(hi, ok_hi, p_hi, f_hi);
    rx_byte(lo, ok_lo, p_lo, f_lo);
    checks++; if ({hi, lo} !== 16'h0301) begin failures++; $display("FAIL par_word got=%h exp=0301", {hi, lo}); end
    checks++; if (p_hi !== 1'b0) begin failures++; $display("FAIL par_high got=%b exp=0", p_hi); end
    checks++; if (p_lo !== 1'b1) begin failures++; $display("FAIL par_low got=%b exp=1", p_lo); end
    while (cyc < c0 + 1 + 88) step(1);
    checks++; if (bus.BUSY !== 1'b1) begin failures++; $display("FAIL par_busy_last got=%b exp=1", bus.BUSY); end
    step(1);
    checks++; if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL par_busy_clear got=%b exp=0", bus.BUSY); end
  endtask
`endif

  initial begin
    bus.IO64_IN = 16'h0000;
    test_reset();
    test_no_traffic();
    test_basic_frame();
    test_overflow();
    test_full_pop();
    test_reset_mid_frame();
`ifdef IO64_UART_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
